// File: rtl/spi_bus_bridge.sv
// SPI-slave bridge: oversampled SCLK, frames {rw, addr, crc, data} to bus strobes and read replies.
// Optional SPI_BRIDGE_CRC_CHECK_EN rejects write frames whose crc field does not match the data.
module spi_bus_bridge #(
    parameter int unsigned address_width  = 15,
    parameter int unsigned data_width     = 16,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned READ_LATENCY   = 1,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     spi_clk_i,
    input  logic                     spi_mosi_i,
    output logic                     spi_miso_o,
    output logic [address_width-1:0] addr_o,
    output logic [data_width-1:0]    wr_data_o,
    output logic                     wr_o,
    output logic                     rd_o,
    input  logic [data_width-1:0]    rd_data_i,
    output logic                     frame_err_o
);

    localparam int unsigned AW = address_width;
    localparam int unsigned DW = data_width;
    localparam int unsigned FL = AW + DW + 9;
    localparam int unsigned CW = $clog2(FL + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned LW = $clog2(READ_LATENCY + 1);
    // The shift register only has to hold what is decoded from it at header or frame end.
`ifdef SPI_BRIDGE_CRC_CHECK_EN
    localparam int unsigned SW = (DW + 7 > AW) ? DW + 7 : AW;
`else
    localparam int unsigned SW = (DW - 1 > AW) ? DW - 1 : AW;
`endif

    typedef enum logic [1:0] {StRxHdr, StRdWait, StRxBody, StCommit} state_e;

    function automatic logic [7:0] crc8(input logic [DW-1:0] d);
        logic [7:0] c;
        c = 8'h9C;
        for (int i = DW - 1; i >= 0; i--) begin
            c = {c[6:0], 1'b0} ^ (((c[7] ^ d[i]) == 1'b1) ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [SW-1:0]          shift_q, shift_d;
    logic                   rw_q, rw_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic [DW-1:0]          wr_data_q, wr_data_d;
    logic                   wr_q, wr_d;
    logic                   rd_q, rd_d;
    logic                   err_q, err_d;
    logic                   miso_q, miso_d;
    logic [DW+7:0]          resp_q, resp_d;
    logic                   resp_vld_q, resp_vld_d;
    logic                   late_q, late_d;
    logic [LW-1:0]          lat_q, lat_d;
    logic [TW-1:0]          idle_q, idle_d;

    logic          sclk_s, mosi_s, rise, fall, crc_ok;
    logic [AW:0]   hdr_word;
    logic [DW-1:0] frame_data;

    assign sclk_s     = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s     = mosi_sync_q[SYNC_STAGES-1];
    assign rise       = sclk_s & ~sclk_prev_q;
    assign fall       = ~sclk_s & sclk_prev_q;
    assign hdr_word   = {shift_q[AW-1:0], mosi_s};
    assign frame_data = {shift_q[DW-2:0], mosi_s};
`ifdef SPI_BRIDGE_CRC_CHECK_EN
    assign crc_ok = (shift_q[DW+6:DW-1] == crc8(frame_data));
`else
    assign crc_ok = 1'b1;
`endif

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_clk_i};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
        sclk_prev_d = sclk_s;
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        wr_data_d   = wr_data_q;
        wr_d        = 1'b0;
        rd_d        = 1'b0;
        err_d       = 1'b0;
        miso_d      = miso_q;
        resp_d      = resp_q;
        resp_vld_d  = resp_vld_q;
        late_d      = late_q;
        lat_d       = lat_q;
        idle_d      = idle_q;

        unique case (state_q)
            StRdWait: begin
                if (lat_q == LW'(READ_LATENCY)) begin
                    resp_d     = {rd_data_i, crc8(rd_data_i)};
                    resp_vld_d = 1'b1;
                    state_d    = StRxBody;
                end else begin
                    lat_d = lat_q + LW'(1);
                end
            end
            StCommit: state_d = StRxHdr;
            default: ;
        endcase

        if (rise) begin
            idle_d  = '0;
            shift_d = {shift_q[SW-2:0], mosi_s};
            cnt_d   = (cnt_q == CW'(FL - 1)) ? '0 : cnt_q + CW'(1);
            if (cnt_q == CW'(AW)) begin
                addr_d     = hdr_word[AW-1:0];
                rw_d       = hdr_word[AW];
                resp_vld_d = 1'b0;
                late_d     = 1'b0;
                lat_d      = '0;
                rd_d       = ~hdr_word[AW];
                state_d    = hdr_word[AW] ? StRxBody : StRdWait;
            end
            // Reply must be ready before the host samples its first bit.
            if (cnt_q == CW'(AW + 1) && !rw_q && !resp_vld_q) begin
                late_d = 1'b1;
            end
            if (cnt_q == CW'(FL - 1)) begin
                state_d = StCommit;
                if (rw_q) begin
                    if (crc_ok) begin
                        wr_d      = 1'b1;
                        wr_data_d = frame_data;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    err_d = late_q;
                end
            end
        end else if (fall) begin
            idle_d = '0;
            miso_d = 1'b0;
            if (cnt_q > CW'(AW) && !rw_q && resp_vld_q && !late_q) begin
                miso_d = resp_q[DW+7];
                resp_d = {resp_q[DW+6:0], 1'b0};
            end
        end else if (cnt_q != '0) begin
            if (idle_q == TW'(TIMEOUT_CYCLES - 1)) begin
                idle_d     = '0;
                cnt_d      = '0;
                state_d    = StRxHdr;
                miso_d     = 1'b0;
                err_d      = 1'b1;
                resp_vld_d = 1'b0;
                late_d     = 1'b0;
            end else begin
                idle_d = idle_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            state_q     <= StRxHdr;
            cnt_q       <= '0;
            shift_q     <= '0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            wr_data_q   <= '0;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            err_q       <= 1'b0;
            miso_q      <= 1'b0;
            resp_q      <= '0;
            resp_vld_q  <= 1'b0;
            late_q      <= 1'b0;
            lat_q       <= '0;
            idle_q      <= '0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            wr_data_q   <= wr_data_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            err_q       <= err_d;
            miso_q      <= miso_d;
            resp_q      <= resp_d;
            resp_vld_q  <= resp_vld_d;
            late_q      <= late_d;
            lat_q       <= lat_d;
            idle_q      <= idle_d;
        end
    end

    assign spi_miso_o  = miso_q;
    assign addr_o      = addr_q;
    assign wr_data_o   = wr_data_q;
    assign wr_o        = wr_q;
    assign rd_o        = rd_q;
    assign frame_err_o = err_q;

endmodule

// File: tb/tb_spi_bus_bridge.sv
// Randomised frame-level bench for spi_bus_bridge against a memory/CRC reference model.
module tb_spi_bus_bridge;

    localparam int HALF = 8;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        spi_clk_i = 1'b0;
    logic        spi_mosi_i = 1'b0;
    logic        spi_miso_o;
    logic [14:0] addr_o;
    logic [15:0] wr_data_o;
    logic        wr_o;
    logic        rd_o;
    logic [15:0] rd_data_i = '0;
    logic        frame_err_o;

    always #5 clk_i = ~clk_i;

    spi_bus_bridge dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .spi_clk_i   (spi_clk_i),
        .spi_mosi_i  (spi_mosi_i),
        .spi_miso_o  (spi_miso_o),
        .addr_o      (addr_o),
        .wr_data_o   (wr_data_o),
        .wr_o        (wr_o),
        .rd_o        (rd_o),
        .rd_data_i   (rd_data_i),
        .frame_err_o (frame_err_o)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bus slave seen by the DUT, plus strobe observers.
    bit [15:0]   bus_mem [0:32767];
    int unsigned wr_cnt = 0, rd_cnt = 0, err_cnt = 0, both_cnt = 0;
    logic [14:0] wr_addr_seen = '0;
    logic [15:0] wr_data_seen = '0;

    always @(negedge clk_i) begin
        if (wr_o) begin
            wr_cnt++;
            wr_addr_seen = addr_o;
            wr_data_seen = wr_data_o;
            bus_mem[addr_o] = wr_data_o;
        end
        if (rd_o) begin
            rd_cnt++;
            rd_data_i = bus_mem[addr_o];
        end
        if (frame_err_o) err_cnt++;
        if (wr_o && rd_o) both_cnt++;
    end

    // Reference model: expected memory contents and CRC as GF(2) polynomial remainder.
    bit [15:0] exp_mem [0:32767];

    function automatic logic [7:0] ref_crc(input logic [15:0] d);
        logic [23:0] v;
        v = {8'h9C, 16'h0000} ^ {d, 8'h00};
        for (int b = 23; b >= 8; b--) begin
            if (v[b]) v = v ^ (24'h107 << (b - 8));
        end
        return v[7:0];
    endfunction

    function automatic bit write_accepted(input logic [7:0] crc, input logic [15:0] data);
`ifdef SPI_BRIDGE_CRC_CHECK_EN
        return crc == ref_crc(data);
`else
        return 1'b1;
`endif
    endfunction

    task automatic spi_frame(input logic rw, input logic [14:0] addr, input logic [7:0] crc,
                             input logic [15:0] data, input int nbits,
                             output logic [39:0] miso);
        logic [39:0] word;
        word = {rw, addr, crc, data};
        miso = '0;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi_i = word[39-i];
            repeat (HALF) @(negedge clk_i);
            miso[39-i] = spi_miso_o;
            spi_clk_i = 1'b1;
            repeat (HALF) @(negedge clk_i);
            spi_clk_i = 1'b0;
        end
        repeat (HALF) @(negedge clk_i);
    endtask

    task automatic do_write(input string tag, input logic [14:0] addr, input logic [15:0] data,
                            input logic [7:0] crc);
        int unsigned w0, r0, e0;
        logic [39:0] m;
        bit ok;
        ok = write_accepted(crc, data);
        w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
        spi_frame(1'b1, addr, crc, data, 40, m);
        check_eq({tag, "_wr"}, 64'(wr_cnt - w0), 64'(ok));
        check_eq({tag, "_err"}, 64'(err_cnt - e0), 64'(!ok));
        check_eq({tag, "_rd"}, 64'(rd_cnt - r0), 64'd0);
        check_eq({tag, "_miso"}, 64'(m), 64'd0);
        if (ok) begin
            check_eq({tag, "_addr"}, 64'(wr_addr_seen), 64'(addr));
            check_eq({tag, "_data"}, 64'(wr_data_seen), 64'(data));
            exp_mem[addr] = data;
        end
    endtask

    task automatic do_read(input string tag, input logic [14:0] addr);
        int unsigned w0, r0, e0;
        logic [39:0] m;
        logic [15:0] d;
        d = exp_mem[addr];
        w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
        spi_frame(1'b0, addr, 8'($urandom), 16'($urandom), 40, m);
        check_eq({tag, "_rd"}, 64'(rd_cnt - r0), 64'd1);
        check_eq({tag, "_wr"}, 64'(wr_cnt - w0), 64'd0);
        check_eq({tag, "_err"}, 64'(err_cnt - e0), 64'd0);
        check_eq({tag, "_miso"}, 64'(m), 64'({16'h0000, d, ref_crc(d)}));
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq(tag, 64'({addr_o, wr_data_o, wr_o, rd_o, spi_miso_o, frame_err_o}), 64'd0);
    endtask

    initial begin
        int unsigned w0, e0;
        logic [39:0] m;
        logic [14:0] a;
        logic [15:0] d;

        repeat (4) @(negedge clk_i);
        check_idle_outputs("reset_hold");
        reset_i = 1'b0;
        repeat (4) @(negedge clk_i);
        check_idle_outputs("reset_release");

        do_write("t1", 15'h0010, 16'hA5C3, 8'h00);
        do_write("t1b", 15'h0010, 16'hA5C3, ref_crc(16'hA5C3));
        do_read("t2", 15'h0010);

        do_write("t3w", 15'h0020, 16'h0000, ref_crc(16'h0000));
        do_read("t3r", 15'h0020);

        w0 = wr_cnt; e0 = err_cnt;
        spi_frame(1'b1, 15'h0031, ref_crc(16'hBEEF), 16'hBEEF, 20, m);
        repeat (300) @(negedge clk_i);
        check_eq("t4_err", 64'(err_cnt - e0), 64'd1);
        check_eq("t4_wr", 64'(wr_cnt - w0), 64'd0);
        do_write("t4w", 15'h0031, 16'h5A5A, ref_crc(16'h5A5A));
        do_read("t4r", 15'h0031);

        do_write("t5bad", 15'h0042, 16'h1234, 8'h00);
        do_write("t5good", 15'h0042, 16'h1234, ref_crc(16'h1234));
        do_read("t5r", 15'h0042);

        w0 = wr_cnt;
        spi_frame(1'b1, 15'h0055, ref_crc(16'hC0DE), 16'hC0DE, 30, m);
        reset_i = 1'b1;
        repeat (3) @(negedge clk_i);
        check_idle_outputs("t6_reset");
        reset_i = 1'b0;
        repeat (HALF) @(negedge clk_i);
        check_eq("t6_wr", 64'(wr_cnt - w0), 64'd0);
        check_idle_outputs("t6_after");

        for (int i = 0; i < 10; i++) begin
            a = 15'($urandom_range(0, 32767));
            d = 16'($urandom);
            do_write($sformatf("rnd%0d", i), a, d, ref_crc(d));
            do_read($sformatf("rnd%0d", i), a);
        end

        check_eq("rd_wr_overlap", 64'(both_cnt), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
